region_scanner: RTL
===================

REGION_SCANNER -- requirements
Module: region_scanner

Interface
REQ-001 Parameter COORD_W, default 27: signed fixed-point coordinate width.
REQ-002 Parameter ITER_W, default 32: solver iteration-count width.
REQ-003 Parameter OUT_W, default 4: output shade width.
REQ-004 Parameter OUT_LSB, default 4: iteration-count bit mapped to shade LSB.
REQ-005 Parameter SOLVER_ID, default 0: this scanner's row offset within the interleave group.
REQ-006 Parameter NUM_SOLVERS, default 1: row interleave stride.
REQ-007 Parameter DIM_W, default 10: width of the column and row counters and sizes.
REQ-008 clock  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to latch configuration and begin a scan.
REQ-010 abort  in  1  terminate the current scan and return to IDLE.
REQ-011 min_x, min_y, dx, dy  in  COORD_W each  signed region origin and per-pixel step.
REQ-012 num_cols, num_rows  in  DIM_W each  region size in pixels.
REQ-013 solv_start  out  1  one-cycle pulse that launches the external solver.
REQ-014 solv_c_re, solv_c_im  out  COORD_W each  coordinate presented to the solver, held stable from solv_start until solv_ready.
REQ-015 solv_ready  in  1  one-cycle pulse: solver result valid.
REQ-016 solv_iter  in  ITER_W  solver iteration count, valid with solv_ready.
REQ-017 out_valid  out  1; out_ready  in  1: output handshake.
REQ-018 out_col, out_row  out  DIM_W each; out_value  out  OUT_W: pixel result.
REQ-019 busy  out  1  asserted in any state other than IDLE and DONE; done  out  1  asserted in DONE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, EMIT and DONE.
REQ-021 In IDLE or DONE, start SHALL latch all configuration inputs, set col=0, row=SOLVER_ID, x=min_x, y=min_y+SOLVER_ID*dy, and precompute y_stride=NUM_SOLVERS*dy truncated to COORD_W.
REQ-022 On start, the FSM SHALL go to DONE if num_cols==0, num_rows==0 or SOLVER_ID>=num_rows, and to ISSUE otherwise.
REQ-023 start SHALL be ignored in ISSUE, WAIT and EMIT.
REQ-024 ISSUE SHALL assert solv_start for exactly one cycle and then enter WAIT, so solv_start rises the cycle after start is accepted.
REQ-025 In WAIT, solv_ready SHALL capture the shade and enter EMIT; out_valid SHALL rise the next cycle.
REQ-026 Shade SHALL be solv_iter>>OUT_LSB, saturated to 2^OUT_W-1; a negative solv_iter SHALL yield 0.
REQ-027 In EMIT, out_valid SHALL stay high with out_col, out_row and out_value stable until out_ready is sampled high.
REQ-028 On the EMIT handshake, if col==num_cols-1: col=0, x=min_x, row+=NUM_SOLVERS, y+=y_stride; otherwise col+=1 and x+=dx.
REQ-029 After the EMIT handshake, the FSM SHALL enter DONE if the emitted pixel was the last column and row+NUM_SOLVERS>=num_rows, and ISSUE otherwise.
REQ-030 Coordinate sums SHALL wrap modulo 2^COORD_W in two's complement; the row compare SHALL use DIM_W+1 bits so row overflow is not lost.
REQ-031 solv_ready outside WAIT SHALL be ignored.
REQ-032 abort SHALL take priority over every other input except reset, forcing IDLE the next cycle with out_valid=0 and solv_start=0.
REQ-033 If abort and start are asserted together, abort SHALL win and start SHALL be dropped.
REQ-034 done SHALL remain high until an accepted start or abort.

Reset
REQ-035 Reset SHALL force IDLE and set solv_start=0, out_valid=0, busy=0, done=0, out_col=0, out_row=0, out_value=0 and solv_c_re=solv_c_im=0.
REQ-036 Reset asserted mid-scan SHALL discard all progress; a subsequent solv_ready SHALL be ignored.

Verification
REQ-037 NUM_SOLVERS=1, 3x2 region, min=(0,0), d=(1,1), solver returns iter=0x25, out_ready=1: six outputs in order (0,0)...(2,1), each out_value=2, then done=1.
REQ-038 NUM_SOLVERS=4, SOLVER_ID=1, num_rows=6, num_cols=2: only rows 1 and 5 emitted, with y stepping by 4*dy; SOLVER_ID=7 with the same region goes to done the cycle after start.
REQ-039 out_ready held low 5 cycles while out_valid=1: outputs stable, no solv_start pulse; the next solv_start follows the cycle after the handshake.
REQ-040 solv_iter=0x7FF with OUT_W=4, OUT_LSB=4: out_value=15 (saturated); solv_iter=0x8000_0000: out_value=0.
REQ-041 abort during WAIT, then a stray solv_ready: FSM in IDLE, no out_valid; a new start runs a full scan correctly.
REQ-042 num_cols=0: done asserted the cycle after start and solv_start never pulses; start in DONE restarts the scan.

Source files
------------

// File: rtl/region_scanner_if.sv
// Solver and pixel-output handshake bundle for region_scanner.
// The master side is the scanner. The slave side is the solver or pixel sink.
interface region_scanner_if #(
  parameter int COORD_W = 27,
  parameter int ITER_W  = 32,
  parameter int OUT_W   = 4,
  parameter int DIM_W   = 10
);
  logic               solv_start;
  logic [COORD_W-1:0] solv_c_re;
  logic [COORD_W-1:0] solv_c_im;
  logic               solv_ready;
  logic [ITER_W-1:0]  solv_iter;

  logic               out_valid;
  logic               out_ready;
  logic [DIM_W-1:0]   out_col;
  logic [DIM_W-1:0]   out_row;
  logic [OUT_W-1:0]   out_value;

  modport master (
    output solv_start, solv_c_re, solv_c_im, out_valid, out_col, out_row, out_value,
    input  solv_ready, solv_iter, out_ready
  );

  modport slave (
    input  solv_start, solv_c_re, solv_c_im, out_valid, out_col, out_row, out_value,
    output solv_ready, solv_iter, out_ready
  );
endinterface

// File: rtl/region_scanner.sv
// Raster scanner over a rectangular region of the complex plane.
// For each pixel the scanner launches the external solver and waits for its result.
// The iteration count returned by the solver is mapped to a shade and emitted on a
// valid/ready port. Rows are interleaved across NUM_SOLVERS scanners. This instance
// handles rows SOLVER_ID, SOLVER_ID+NUM_SOLVERS, and so on.
//
// state | meaning
// IDLE  | no scan in progress; waiting for start
// ISSUE | solv_start is high for this single cycle
// WAIT  | coordinate held; waiting for solv_ready
// EMIT  | out_valid is high; waiting for out_ready
// DONE  | scan complete; done is high until a start or an abort
module region_scanner #(
  parameter int COORD_W     = 27,
  parameter int ITER_W      = 32,
  parameter int OUT_W       = 4,
  parameter int OUT_LSB     = 4,
  parameter int SOLVER_ID   = 0,
  parameter int NUM_SOLVERS = 1,
  parameter int DIM_W       = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  input  logic [DIM_W-1:0]   num_cols,
  input  logic [DIM_W-1:0]   num_rows,
  output logic               busy,
  output logic               done,
  region_scanner_if.master   bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;

  localparam logic [DIM_W:0]   SID_R    = (DIM_W+1)'(SOLVER_ID);
  localparam logic [DIM_W:0]   NS_R     = (DIM_W+1)'(NUM_SOLVERS);
  localparam logic [COORD_W-1:0] SID_C  = COORD_W'(SOLVER_ID);
  localparam logic [COORD_W-1:0] NS_C   = COORD_W'(NUM_SOLVERS);
  localparam logic [ITER_W-1:0] SHADE_MAX = ITER_W'((1 << OUT_W) - 1);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   col_q, col_d;
  logic [DIM_W:0]     row_q, row_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d;
  logic [COORD_W-1:0] dx_q, dx_d;
  logic [COORD_W-1:0] y_stride_q, y_stride_d;
  logic [DIM_W-1:0]   num_cols_q, num_cols_d;
  logic [DIM_W-1:0]   num_rows_q, num_rows_d;
  logic [OUT_W-1:0]   shade_q, shade_d;
  logic               solv_start_q, solv_start_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ITER_W-1:0]  iter_shift;
  logic [OUT_W-1:0]   shade;
  logic               last_col;
  logic [DIM_W:0]     row_next;

  // Map the solver iteration count to a shade: negative counts give 0 and large counts saturate.
  always_comb begin
    iter_shift = bus.solv_iter >> OUT_LSB;
    shade      = '0;
    if (bus.solv_iter[ITER_W-1]) begin
      shade = '0;
    end else if (iter_shift > SHADE_MAX) begin
      shade = '1;
    end else begin
      shade = iter_shift[OUT_W-1:0];
    end
  end

  // Next-state and next-output logic for the scan sequencer. Abort overrides every branch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    min_x_d      = min_x_q;
    dx_d         = dx_q;
    y_stride_d   = y_stride_q;
    num_cols_d   = num_cols_q;
    num_rows_d   = num_rows_q;
    shade_d      = shade_q;
    solv_start_d = 1'b0;
    out_valid_d  = out_valid_q;
    last_col     = (col_q == (num_cols_q - DIM_W'(1)));
    row_next     = row_q + NS_R;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          min_x_d    = min_x;
          dx_d       = dx;
          y_stride_d = NS_C * dy;
          num_cols_d = num_cols;
          num_rows_d = num_rows;
          col_d      = '0;
          row_d      = SID_R;
          x_d        = min_x;
          y_d        = min_y + SID_C * dy;
          if (num_cols == '0 || num_rows == '0 || SID_R >= {1'b0, num_rows}) begin
            state_d = DONE;
          end else begin
            state_d      = ISSUE;
            solv_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.solv_ready) begin
          shade_d     = shade;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (last_col) begin
            col_d = '0;
            x_d   = min_x_q;
            row_d = row_next;
            y_d   = y_q + y_stride_q;
          end else begin
            col_d = col_q + DIM_W'(1);
            x_d   = x_q + dx_q;
          end
          if (last_col && row_next >= {1'b0, num_rows_q}) begin
            state_d = DONE;
          end else begin
            state_d      = ISSUE;
            solv_start_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d      = IDLE;
      solv_start_d = 1'b0;
      out_valid_d  = 1'b0;
    end

    busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      min_x_q      <= '0;
      dx_q         <= '0;
      y_stride_q   <= '0;
      num_cols_q   <= '0;
      num_rows_q   <= '0;
      shade_q      <= '0;
      solv_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      min_x_q      <= min_x_d;
      dx_q         <= dx_d;
      y_stride_q   <= y_stride_d;
      num_cols_q   <= num_cols_d;
      num_rows_q   <= num_rows_d;
      shade_q      <= shade_d;
      solv_start_q <= solv_start_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.solv_start = solv_start_q;
  assign bus.solv_c_re  = x_q;
  assign bus.solv_c_im  = y_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_col    = col_q;
  assign bus.out_row    = row_q[DIM_W-1:0];
  assign bus.out_value  = shade_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
